// File: rtl/adc_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_apb_pkg
// Description : Shared definitions for the ADC/FIFO APB peripheral: register
//               map, measurement field widths, status bit positions and the
//               sample-formatting helper used by the dummy ADC.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_apb_pkg;

    // Register map (byte addresses)
    localparam int unsigned STATUS_REG_ADDR     = 32'h000;
    localparam int unsigned ADC_TRIGGER_ADDR    = 32'h004;
    localparam int unsigned MEASUREMENT_HI_ADDR = 32'h008;
    localparam int unsigned MEASUREMENT_LO_ADDR = 32'h00C;

    // Measurement geometry: one 56-bit sample read as a 32-bit high word and
    // a 24-bit low word.
    localparam int SAMPLE_W = 56;
    localparam int HI_W     = 32;
    localparam int LO_W     = 24;

    // Status register bit positions
    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_MSB = 7;

    // Fixed tag carried in the upper half of every high word
    localparam logic [HI_W-1:0] ADC_HI_TAG = 32'hADC0_0000;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Build a measurement from sample counter value k: the high word carries
    // the tag with k[15:0] in its lower half, the low word is k itself.
    function automatic sample_t adc_sample(input logic [LO_W-1:0] k);
        logic [HI_W-1:0] hi;
        hi = ADC_HI_TAG | {16'h0000, k[15:0]};
        return {hi, k};
    endfunction

endpackage : adc_apb_pkg
`default_nettype wire

// File: rtl/adc_apb_fifo_wrapper_adc.sv
`default_nettype none
// ============================================================================
// Module      : dummy_adc
// Description : Stand-in ADC. Each start pulse increments a 24-bit sample
//               counter and presents the next measurement for one cycle.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset
//               i_start  - conversion request (one cycle per sample)
//               o_valid  - measurement valid, high for one cycle per start
//               o_sample - 56-bit measurement
// Revision    : 1.0 - initial release
// ============================================================================
module dummy_adc
    import adc_apb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_start,
    output logic    o_valid,
    output sample_t o_sample
);

    logic [LO_W-1:0] r_k;
    logic            r_valid;
    sample_t         r_sample;
    logic [LO_W-1:0] w_k_next;

    assign w_k_next = r_k + LO_W'(1);

    // No busy state: a start on every cycle yields a sample on every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k      <= '0;
            r_valid  <= 1'b0;
            r_sample <= '0;
        end else begin
            r_valid <= i_start;
            if (i_start) begin
                r_k      <= w_k_next;
                r_sample <= adc_sample(w_k_next);
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_sample = r_sample;

endmodule : dummy_adc
`default_nettype wire

// File: rtl/adc_apb_fifo_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : adc_apb_fifo_wrapper
// Description : APB3 slave wrapping a dummy ADC and a measurement FIFO.
//               Writing bit0=1 to the trigger register produces one sample,
//               which is queued. Software reads the high word, then the low
//               word; the low-word read dequeues the entry.
// Ports       : PCLK    - clock, rising edge
//               PRESETn - synchronous reset, ACTIVE-HIGH despite its name
//               PSEL, PENABLE, PWRITE, PADDR, PWDATA - APB request
//               PRDATA  - combinational read data (0 unless a mapped read)
//               PREADY  - tied 1, no wait states
//               PSLVERR - access to an unmapped address
// Revision    : 1.0 - initial release
// ============================================================================
module adc_apb_fifo_wrapper
    import adc_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
)(
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // The reset port keeps its historical name but is active-high.
    logic w_rst;
    assign w_rst = PRESETn;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic w_access, w_wr_access, w_rd_access;
    logic w_sel_status, w_sel_trig, w_sel_hi, w_sel_lo, w_mapped;

    assign w_access    = PSEL & PENABLE;
    assign w_wr_access = w_access & PWRITE;
    assign w_rd_access = w_access & ~PWRITE;

    assign w_sel_status = (PADDR == ADDR_WIDTH'(STATUS_REG_ADDR));
    assign w_sel_trig   = (PADDR == ADDR_WIDTH'(ADC_TRIGGER_ADDR));
    assign w_sel_hi     = (PADDR == ADDR_WIDTH'(MEASUREMENT_HI_ADDR));
    assign w_sel_lo     = (PADDR == ADDR_WIDTH'(MEASUREMENT_LO_ADDR));
    assign w_mapped     = w_sel_status | w_sel_trig | w_sel_hi | w_sel_lo;

    // Only bit0 (trigger) and bit2 (overflow clear) of write data matter.
    logic w_unused_pwdata;
    assign w_unused_pwdata = ^{PWDATA[DATA_WIDTH-1:3], PWDATA[1]};

    logic w_adc_start, w_ovf_clear;
    assign w_adc_start = w_wr_access & w_sel_trig   & PWDATA[0];
    assign w_ovf_clear = w_wr_access & w_sel_status & PWDATA[2];

    // ------------------------------------------------------------------
    // Dummy ADC
    // ------------------------------------------------------------------
    logic    w_adc_valid;
    sample_t w_adc_sample;

    dummy_adc u_adc (
        .clk      (PCLK),
        .rst      (w_rst),
        .i_start  (w_adc_start),
        .o_valid  (w_adc_valid),
        .o_sample (w_adc_sample)
    );

    // ------------------------------------------------------------------
    // Measurement FIFO
    // ------------------------------------------------------------------
    sample_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic    w_not_empty, w_full, w_push, w_pop, w_drop;
    sample_t w_head;

    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_head      = r_mem[r_rd_ptr];

    // A low-word read of a non-empty FIFO pops. Because the pop frees the
    // head slot at the same edge, a push into a full FIFO is accepted when
    // it coincides with a pop.
    assign w_pop  = w_rd_access & w_sel_lo & w_not_empty;
    assign w_push = w_adc_valid & (~w_full | w_pop);
    assign w_drop = w_adc_valid & w_full & ~w_pop;

    always_ff @(posedge PCLK) begin
        if (w_push && !w_rst) begin
            r_mem[r_wr_ptr] <= w_adc_sample;
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set so the
            // loss is never hidden from software.
            if (w_ovf_clear) begin
                r_overflow <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status register and read mux
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] status_reg;

    always_comb begin
        status_reg                             = '0;
        status_reg[ST_NOT_EMPTY]               = w_not_empty;
        status_reg[ST_FULL]                    = w_full;
        status_reg[ST_OVERFLOW]                = r_overflow;
        status_reg[ST_COUNT_MSB:ST_COUNT_LSB]  = 4'(r_count);
    end

    // Read data is driven during both APB phases of a read so it is stable
    // by the access phase; unmapped addresses fall through to zero.
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            if (w_sel_status) begin
                PRDATA = status_reg;
            end else if (w_sel_hi && w_not_empty) begin
                PRDATA = DATA_WIDTH'(w_head[SAMPLE_W-1:LO_W]);
            end else if (w_sel_lo && w_not_empty) begin
                PRDATA = DATA_WIDTH'(w_head[LO_W-1:0]);
            end
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & ~w_mapped;

endmodule : adc_apb_fifo_wrapper
`default_nettype wire

// File: tb/tb_adc_apb_fifo_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_apb_fifo_wrapper
// Description : Self-checking bench for adc_apb_fifo_wrapper. A queue-based
//               reference model tracks the measurement FIFO, sample counter
//               and overflow flag; directed steps follow the test plan, then
//               a randomized mix of APB accesses is checked against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_apb_fifo_wrapper;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          PSEL;
    logic [AW-1:0] PADDR;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int n_vec = 0;
    int n_err = 0;

    always #5 PCLK = ~PCLK;

    adc_apb_fifo_wrapper #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PADDR   (PADDR),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [55:0] q[$];
    int unsigned mk;
    bit          movf;
    bit          mpend;
    logic [55:0] mpend_s;

    function automatic logic [55:0] model_sample(input int unsigned k);
        logic [31:0] hi;
        logic [23:0] lo;
        hi = 32'hADC0_0000 + (k % 65536);
        lo = 24'(k % (1 << 24));
        return {hi, lo};
    endfunction

    function automatic void model_reset();
        q.delete();
        mk    = 0;
        movf  = 0;
        mpend = 0;
    endfunction

    // One rising edge: the sample requested at the previous edge lands now,
    // a low-word read pops the old head, and this edge's trigger is queued.
    function automatic void model_clock(input bit trig, input bit pop, input bit clr);
        bit popped;
        popped = pop && (q.size() != 0);
        if (popped) void'(q.pop_front());
        if (clr) movf = 0;
        if (mpend) begin
            if (q.size() < DEPTH) q.push_back(mpend_s);
            else                  movf = 1;
        end
        mpend = trig;
        if (trig) begin
            mk      = mk + 1;
            mpend_s = model_sample(mk);
        end
    endfunction

    function automatic logic [31:0] exp_status();
        int unsigned n;
        n = q.size();
        return n * 16 + (movf ? 4 : 0) + ((n == DEPTH) ? 2 : 0) + ((n != 0) ? 1 : 0);
    endfunction

    function automatic bit is_mapped(input logic [AW-1:0] a);
        return (a == 12'h000) || (a == 12'h004) || (a == 12'h008) || (a == 12'h00C);
    endfunction

    function automatic logic [31:0] exp_read(input logic [AW-1:0] a);
        logic [55:0] h;
        if (a == 12'h000) return exp_status();
        if ((a == 12'h008 || a == 12'h00C) && q.size() != 0) begin
            h = q[0];
            if (a == 12'h008) return h[55:24];
            return {8'h00, h[23:0]};
        end
        return 32'h0;
    endfunction

    // ------------------------------------------------------------------
    // Checking and bus tasks
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single-cycle access (setup and access phases merged). Called just after
    // a rising edge; returns 1 time unit after the closing edge.
    task automatic access(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rdata, output logic err);
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        #1;
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK);
        model_clock(wr && a == 12'h004 && wd[0], !wr && a == 12'h00C, wr && a == 12'h000 && wd[2]);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
    endtask

    task automatic do_rd(input string tag, input logic [AW-1:0] a, output logic [DW-1:0] rdata);
        logic [31:0] e;
        logic        ee;
        logic        err;
        e  = exp_read(a);
        ee = !is_mapped(a);
        access(a, 1'b0, '0, rdata, err);
        check(tag, rdata, e);
        check({tag, "_slverr"}, 32'(err), 32'(ee));
    endtask

    task automatic do_wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        logic [DW-1:0] rd;
        logic          err;
        logic          ee;
        ee = !is_mapped(a);
        access(a, 1'b1, wd, rd, err);
        check({tag, "_slverr"}, 32'(err), 32'(ee));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge PCLK);
            model_clock(1'b0, 1'b0, 1'b0);
            #1;
        end
    endtask

    task automatic do_reset();
        PRESETn = 1'b1;
        @(posedge PCLK);
        model_reset();
        #1;
        PRESETn = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [DW-1:0] rd;
        logic [AW-1:0] odd_addr [5];
        logic [DW-1:0] wd;

        odd_addr[0] = 12'h010;
        odd_addr[1] = 12'h7FC;
        odd_addr[2] = 12'h002;
        odd_addr[3] = 12'h008;
        odd_addr[4] = 12'h004;

        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        PRESETn = 1'b1;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        PRESETn = 1'b0;

        // Reset state
        check("pready", 32'(PREADY), 32'h1);
        check("slverr_idle", 32'(PSLVERR), 32'h0);
        check("prdata_idle", PRDATA, 32'h0);
        check("status_reg_lo", 32'(dut.status_reg[1:0]), 32'h0);
        do_rd("status_reset", 12'h000, rd);

        // Single trigger and readback
        do_wr("trig1", 12'h004, 32'h1);
        idle(1);
        do_rd("status_one", 12'h000, rd);
        check("status_one_lit", rd, 32'h0000_0011);
        do_rd("hi_one", 12'h008, rd);
        check("hi_one_lit", rd, 32'hADC0_0001);
        do_rd("lo_one", 12'h00C, rd);
        check("lo_one_lit", rd, 32'h0000_0001);
        do_rd("status_after_pop", 12'h000, rd);

        // Trigger with bit0 clear does nothing
        do_wr("trig0", 12'h004, 32'hFFFF_FFFE);
        idle(2);
        do_rd("status_trig0", 12'h000, rd);

        // Overflow: nine back-to-back triggers from a fresh reset
        do_reset();
        repeat (9) do_wr("trig9", 12'h004, 32'h1);
        idle(1);
        do_rd("status_ovf", 12'h000, rd);
        check("status_ovf_lit", rd, 32'h0000_0087);
        check("status_reg_full", 32'(dut.status_reg[1:0]), 32'h3);
        for (int i = 1; i <= 8; i++) begin
            do_rd("hi_seq", 12'h008, rd);
            check("hi_seq_lit", rd, 32'hADC0_0000 + 32'(i));
            do_rd("lo_seq", 12'h00C, rd);
            check("lo_seq_lit", rd, 32'(i));
        end
        do_rd("status_drained", 12'h000, rd);
        check("status_drained_lit", rd, 32'h0000_0004);
        do_wr("ovf_clear", 12'h000, 32'h4);
        do_rd("status_cleared", 12'h000, rd);
        check("status_cleared_lit", rd, 32'h0);

        // Empty pop and unmapped address
        do_rd("lo_empty", 12'h00C, rd);
        check("lo_empty_lit", rd, 32'h0);
        do_rd("status_empty", 12'h000, rd);
        check("status_empty_lit", rd, 32'h0);
        do_rd("unmapped", 12'h010, rd);
        do_wr("ro_write", 12'h008, 32'hFFFF_FFFF);

        // Push and pop in the same cycle on a full FIFO
        repeat (8) do_wr("fill", 12'h004, 32'h1);
        idle(1);
        do_rd("status_full", 12'h000, rd);
        do_wr("trig_full", 12'h004, 32'h1);
        do_rd("lo_concurrent", 12'h00C, rd);
        idle(1);
        do_rd("status_concurrent", 12'h000, rd);
        check("status_concurrent_lit", rd, 32'h0000_0083);

        // Reset mid-operation with an in-flight sample
        do_reset();
        repeat (3) do_wr("trig3", 12'h004, 32'h1);
        idle(1);
        do_wr("trig_inflight", 12'h004, 32'h1);
        do_reset();
        idle(1);
        do_rd("status_after_rst", 12'h000, rd);
        check("status_after_rst_lit", rd, 32'h0);
        do_wr("trig_post_rst", 12'h004, 32'h1);
        idle(1);
        do_rd("hi_post_rst", 12'h008, rd);
        check("hi_post_rst_lit", rd, 32'hADC0_0001);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    wd    = $urandom;
                    wd[0] = ($urandom_range(0, 3) != 0);
                    do_wr("rnd_trig", 12'h004, wd);
                end
                3:    do_rd("rnd_status", 12'h000, rd);
                4:    do_rd("rnd_hi", 12'h008, rd);
                5, 6: do_rd("rnd_lo", 12'h00C, rd);
                7:    do_wr("rnd_stwr", 12'h000, $urandom);
                8: begin
                    if ($urandom_range(0, 1) == 1)
                        do_wr("rnd_oddwr", odd_addr[$urandom_range(0, 4)], $urandom & 32'hFFFF_FFFE);
                    else
                        do_rd("rnd_oddrd", odd_addr[$urandom_range(0, 4)], rd);
                end
                default: idle($urandom_range(0, 2));
            endcase
        end
        idle(1);
        do_rd("final_status", 12'h000, rd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_adc_apb_fifo_wrapper
`default_nettype wire
